serial_frame_rx: RTL and testbench

Serial frame receiver sitting directly downstream of the 4-stage serial-in/serial-out delay line. It consumes the delayed bit stream one bit per clock, detects a start bit, and assembles WIDTH data bits LSB-first. It checks an optional even parity bit and the stop bit, then presents the word on a parallel valid/ready output with error flags.

---
 rtl/serial_frame_rx_if.sv | 27 ++
 rtl/serial_frame_rx.sv | 107 ++++++++++
 tb/tb_serial_frame_rx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Parallel word handshake between the serial receiver and its consumer.
// The receiver owns the word and flags; the consumer owns ready.
interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             ready;
  logic             parity_err;
  logic             frame_err;

  modport master (
    output dout,
    output valid,
    output parity_err,
    output frame_err,
    input  ready
  );

  modport slave (
    input  dout,
    input  valid,
    input  parity_err,
    input  frame_err,
    output ready
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even
// parity, stop bit, then a registered valid/ready word with flags.
module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            si,
  serial_frame_rx_if.master rx,
  output logic            overrun,
  output logic            busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             pbit;
  logic             last;
  logic             take;
  logic             drop;
  logic             clear;
  logic             perr;

  assign last = (cnt == CW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state decode; a low line in BREAK is never a start bit
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (!si) nxt = DATA;
      DATA:    if (last) nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  nxt = STOP;
      STOP:    nxt = si ? IDLE : BREAK;
      BREAK:   if (si) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // delivery decisions on the stop edge and the plain handshake
  always_comb begin
    take  = 1'b0;
    drop  = 1'b0;
    clear = 1'b0;
    busy  = (state != IDLE);
    perr  = PARITY_EN ? ((^shreg) ^ pbit) : 1'b0;
    unique case (1'b1)
      (state == STOP): begin
        take = !rx.valid || rx.ready;
        drop = rx.valid && !rx.ready;
      end
      default: clear = rx.valid && rx.ready;
    endcase
  end

  // bit counter, shift register and captured parity bit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
      pbit  <= 1'b0;
    end else begin
      if (state == DATA) begin
        shreg[cnt] <= si;
        cnt        <= last ? '0 : cnt + 1'b1;
      end
      if (state == PARITY) pbit <= si;
    end
  end

  // registered output word, flags and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.dout       <= '0;
      rx.valid      <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (take) begin
        rx.dout       <= shreg;
        rx.parity_err <= perr;
        rx.frame_err  <= !si;
        rx.valid      <= 1'b1;
      end else if (clear) begin
        rx.valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a frame-level model predicts
// every cycle, literal pins anchor key points of each scenario.
module tb_serial_frame_rx;
  localparam int W = 8;
  localparam bit P = 1'b1;
  localparam int N = 512;

  typedef struct packed {
    logic [W-1:0] d;
    logic         v;
    logic         pe;
    logic         fe;
    logic         ov;
    logic         b;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic si  = 1'b1;
  logic overrun;
  logic busy;

  serial_frame_rx_if #(.WIDTH(W)) bus ();

  serial_frame_rx #(
    .WIDTH(W),
    .PARITY_EN(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .si(si),
    .rx(bus.master),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  bit           s_v [N];
  bit           r_v [N];
  bit           x_v [N];
  obs_t         exp_v [N];
  bit           dn [N];
  logic [W-1:0] dw [N];
  bit           dp [N];
  bit           df [N];
  bit           bz [N];
  int           n = 0;
  int           pin_t [$];
  obs_t         pin_o [$];
  int           errs = 0;
  int           checks = 0;

  function automatic obs_t mk(logic [W-1:0] d, bit v, bit pe,
                              bit fe, bit ov, bit b);
    obs_t o;
    o.d = d; o.v = v; o.pe = pe; o.fe = fe; o.ov = ov; o.b = b;
    return o;
  endfunction

  task automatic put(input bit s, input bit r, input bit x);
    s_v[n] = s; r_v[n] = r; x_v[n] = x;
    n++;
  endtask

  task automatic idle(input int k, input bit r);
    repeat (k) put(1'b1, r, 1'b0);
  endtask

  task automatic frame(input logic [W-1:0] w, input bit pb,
                       input bit st, input bit r, input bit rs,
                       output int se);
    put(1'b0, r, 1'b0);
    for (int i = 0; i < W; i++) put(w[i], r, 1'b0);
    if (P) put(pb, r, 1'b0);
    se = n;
    put(st, rs, 1'b0);
  endtask

  task automatic pin(input int t, input obs_t o);
    pin_t.push_back(t);
    pin_o.push_back(o);
  endtask

  // Parse the line as frames, then replay the word handshake.
  task automatic build_model();
    int i;
    int s;
    int jr;
    logic [W-1:0] w;
    bit pb;
    obs_t cur;
    i = 0;
    while (i < n) begin
      if (x_v[i] || s_v[i]) begin
        i++;
        continue;
      end
      s  = i + W + 1 + int'(P);
      if (s >= n) break;
      jr = -1;
      for (int j = i + 1; j <= s; j++)
        if (jr < 0 && x_v[j]) jr = j;
      if (jr >= 0) begin
        for (int k = i; k < jr; k++) bz[k] = 1'b1;
        i = jr;
        continue;
      end
      for (int b = 0; b < W; b++) w[b] = s_v[i + 1 + b];
      pb = P ? s_v[i + 1 + W] : 1'b0;
      dn[s] = 1'b1;
      dw[s] = w;
      dp[s] = P && (($countones(w) + int'(pb)) % 2 == 1);
      df[s] = !s_v[s];
      for (int k = i; k < s; k++) bz[k] = 1'b1;
      i = s + 1;
      if (!s_v[s]) begin
        bz[s] = 1'b1;
        while (i < n && !x_v[i] && !s_v[i]) begin
          bz[i] = 1'b1;
          i++;
        end
      end
    end
    cur = mk('0, 0, 0, 0, 0, 0);
    for (int t = 0; t < n; t++) begin
      if (x_v[t]) begin
        cur = mk('0, 0, 0, 0, 0, 0);
      end else if (dn[t]) begin
        if (!cur.v || r_v[t]) begin
          cur.d = dw[t]; cur.pe = dp[t];
          cur.fe = df[t]; cur.v = 1'b1;
        end else begin
          cur.ov = 1'b1;
        end
      end else if (cur.v && r_v[t]) begin
        cur.v = 1'b0;
      end
      cur.b = x_v[t] ? 1'b0 : bz[t];
      exp_v[t] = cur;
    end
  endtask

  initial begin
    int s;
    obs_t got;
    bus.ready = 1'b0;

    put(1, 1, 1);
    put(1, 1, 1);
    pin(1, mk(8'h00, 0, 0, 0, 0, 0));
    idle(3, 1);

    frame(8'hA5, 0, 1, 1, 1, s);
    pin(s, mk(8'hA5, 1, 0, 0, 0, 0));
    pin(s + 1, mk(8'hA5, 0, 0, 0, 0, 0));
    idle(2, 1);

    frame(8'h01, 0, 1, 1, 1, s);
    pin(s, mk(8'h01, 1, 1, 0, 0, 0));
    frame(8'h03, 0, 1, 1, 1, s);
    pin(s, mk(8'h03, 1, 0, 0, 0, 0));
    idle(2, 1);

    frame(8'h55, 0, 0, 1, 1, s);
    repeat (5) put(0, 1, 0);
    pin(s, mk(8'h55, 1, 0, 1, 0, 1));
    pin(s + 5, mk(8'h55, 0, 0, 1, 0, 1));
    idle(2, 1);
    pin(s + 6, mk(8'h55, 0, 0, 1, 0, 0));
    frame(8'h12, 0, 1, 1, 1, s);
    pin(s, mk(8'h12, 1, 0, 0, 0, 0));
    idle(3, 1);

    frame(8'h3C, 0, 1, 0, 0, s);
    frame(8'hC3, 0, 1, 0, 0, s);
    pin(s, mk(8'h3C, 1, 0, 0, 1, 0));
    put(1, 1, 0);
    pin(s + 1, mk(8'h3C, 0, 0, 0, 1, 0));
    idle(2, 0);

    put(1, 0, 1);
    idle(2, 0);
    frame(8'h3C, 0, 1, 0, 0, s);
    pin(s, mk(8'h3C, 1, 0, 0, 0, 0));
    frame(8'hC3, 0, 1, 0, 1, s);
    pin(s, mk(8'hC3, 1, 0, 0, 0, 0));
    idle(2, 1);

    put(0, 1, 0);
    put(0, 1, 0);
    put(1, 1, 0);
    put(1, 1, 0);
    put(1, 1, 0);
    put(1, 1, 1);
    pin(n - 1, mk(8'h00, 0, 0, 0, 0, 0));
    idle(2, 1);
    frame(8'h7E, 0, 1, 1, 1, s);
    pin(s, mk(8'h7E, 1, 0, 0, 0, 0));
    idle(3, 1);

    build_model();

    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      si        = s_v[t];
      bus.ready = r_v[t];
      rst       = x_v[t];
      @(posedge clk);
      #1;
      got = mk(bus.dout, bus.valid, bus.parity_err,
               bus.frame_err, overrun, busy);
      checks++;
      if (got !== exp_v[t]) begin
        errs++;
        $display("FAIL cycle %0d: got d=%h v%b pe%b fe%b ov%b b%b want d=%h v%b pe%b fe%b ov%b b%b",
                 t, got.d, got.v, got.pe, got.fe, got.ov, got.b,
                 exp_v[t].d, exp_v[t].v, exp_v[t].pe,
                 exp_v[t].fe, exp_v[t].ov, exp_v[t].b);
      end
      for (int k = 0; k < pin_t.size(); k++) begin
        if (pin_t[k] == t) begin
          checks++;
          if (got !== pin_o[k]) begin
            errs++;
            $display("FAIL pin %0d cycle %0d: got %h want %h",
                     k, t, got, pin_o[k]);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
